// File: rtl/button_debounce_repeat.sv
// button_debounce_repeat: synchronises and debounces a raw push-button, emitting
// registered press/release/click pulses with optional auto-repeat clicks while held.
module button_debounce_repeat #(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, ARM, HELD, REPEAT, DISARM} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   btn_s;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   click_q;

    assign btn_s         = sync_q[SYNC_STAGES-1];
    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click         = click_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q <= ARM;
                        cnt_q   <= '0;
                    end
                end
                ARM: begin
                    if (!btn_s) begin
                        state_q <= IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        click_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_q <= DISARM;
                        cnt_q   <= '0;
                    end else if (!repeat_en) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DLY_LAST) begin
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                        click_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                REPEAT: begin
                    if (!btn_s) begin
                        state_q <= DISARM;
                        cnt_q   <= '0;
                    end else if (!repeat_en) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == PER_LAST) begin
                        cnt_q   <= '0;
                        click_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                DISARM: begin
                    // a bounce back to pressed returns to HELD silently and restarts the repeat delay
                    if (btn_s) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_button_debounce_repeat.sv
// tb_button_debounce_repeat: directed vectors plus randomized stimulus against a
// run-length/elapsed-time reference model of the debounced button.
module tb_button_debounce_repeat;
    localparam int SS  = 2;
    localparam int DEB = 4;
    localparam int RD  = 6;
    localparam int RP  = 3;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic repeat_en = 1'b0;
    logic btn_level, press_pulse, release_pulse, click;

    button_debounce_repeat #(
        .SYNC_STAGES(SS), .CNT_W(CW), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .click(click)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        logic ren;
        logic rst;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[34];
    int   n_pass = 0;
    int   n_total = 0;

    int       m_pipe[$];
    logic     m_lvl;
    int       m_run;
    int       m_el;
    int       m_tgt;
    logic [3:0] m_out;

    function automatic logic [3:0] outs();
        return {btn_level, press_pulse, release_pulse, click};
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: lvl/press/rel/click got %b expected %b", name, $time, got, exp);
    endtask

    // Level flips once DEB+1 consecutive opposite samples have been seen since the last flip;
    // repeat clicks fire once enough enabled, uninterrupted held edges have elapsed.
    task automatic model_edge(input logic x, input logic b, input logic r);
        logic s, pr, rl, ck;
        pr = 1'b0; rl = 1'b0; ck = 1'b0;
        if (x) begin
            m_pipe = {};
            for (int i = 0; i < SS; i++) m_pipe.push_back(0);
            m_lvl = 1'b0; m_run = 0; m_el = 0; m_tgt = RD;
        end else begin
            s = logic'(m_pipe.pop_front());
            m_pipe.push_back(int'(b));
            if (!m_lvl) begin
                m_run = s ? m_run + 1 : 0;
                if (m_run == DEB + 1) begin
                    m_lvl = 1'b1; pr = 1'b1; ck = 1'b1; m_run = 0; m_el = 0; m_tgt = RD;
                end
            end else if (!s) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl = 1'b0; rl = 1'b1; m_run = 0;
                end
            end else if (m_run > 0 || !r) begin
                m_run = 0; m_el = 0; m_tgt = RD;
            end else begin
                m_el++;
                if (m_el == m_tgt) begin
                    ck = 1'b1; m_el = 0; m_tgt = RP;
                end
            end
        end
        m_out = {m_lvl, pr, rl, ck};
    endtask

    task automatic step(input logic b, input logic r, input logic x);
        btn_in = b; repeat_en = r; reset = x;
        @(posedge clk);
        model_edge(x, b, r);
        #1;
        chk("model", outs(), m_out);
    endtask

    task automatic prep();
        step(1'b0, 1'b0, 1'b1);
        chk("reset", outs(), 4'b0000);
        repeat (4) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int len;
        logic b, r, x;
        for (int e = 1; e <= 34; e++)
            vecs[e-1] = '{btn: e <= 25, ren: 1'b1, rst: 1'b0,
                          exp: {e >= 7 && e < 32, e == 7, e == 32, e inside {7, 13, 16, 19, 22, 25}}};

        prep();
        for (int i = 0; i < 34; i++) begin
            step(vecs[i].btn, vecs[i].ren, vecs[i].rst);
            chk("auto_repeat_vec", outs(), vecs[i].exp);
        end

        prep();
        for (int e = 1; e <= 13; e++) begin
            step(e <= 3, 1'b0, 1'b0);
            chk("glitch", outs(), 4'b0000);
        end

        prep();
        for (int e = 1; e <= 20; e++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("clean_press", outs(), {e >= 7, e == 7, 1'b0, e == 7});
        end
        for (int f = 1; f <= 10; f++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("clean_release", outs(), {f < 7, 1'b0, f == 7, 1'b0});
        end

        prep();
        for (int e = 1; e <= 22; e++) begin
            step(!(e == 10 || e == 11), 1'b1, 1'b0);
            chk("release_bounce", outs(), {e >= 7, e == 7, 1'b0, e == 7 || e == 20});
        end

        prep();
        for (int e = 1; e <= 9; e++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("reset_mid_hold", outs(), 4'b0000);
        for (int e = 1; e <= 9; e++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("repress_after_reset", outs(), {e >= 7, e == 7, 1'b0, e == 7});
        end

        prep();
        for (int e = 1; e <= 30; e++) begin
            step(1'b1, !(e >= 17 && e <= 22), 1'b0);
            chk("repeat_en_drop", outs(), {e >= 7, e == 7, 1'b0, e inside {7, 13, 16, 28}});
        end

        prep();
        r = 1'b1;
        for (int k = 0; k < 150; k++) begin
            b = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(5, 30));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 19) == 0) r = ~r;
                x = ($urandom_range(0, 499) == 0);
                step(b, r, x);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/button_debounce_repeat.md
Name: button_debounce_repeat

Overview:
- Upstream conditioning stage for the front-panel push-buttons. It feeds the add/sub inputs of the hex up/down counter with 7-segment display.
- Synchronises a raw, bouncing button and debounces it with a counter-based FSM.
- Emits single-cycle press, release and click pulses. Click optionally auto-repeats while the button is held, so the counter can be stepped quickly.
- One instance per button.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_in (minimum 2).
- CNT_W, 20, width of the shared timing counter.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a level change (10 ms at 100 MHz). Range 1 to 2^CNT_W-1.
- REPEAT_DELAY, 50000000, cycles after an accepted press before the first auto-repeat click. Range 1 to 2^CNT_W-1; the default needs CNT_W>=26 at build time.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat clicks. Range 1 to 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous button level, 1 = pressed.
- repeat_en  input  1  level; 1 enables auto-repeat clicks.
- btn_level  output  1  debounced button level (registered).
- press_pulse  output  1  one-cycle pulse on an accepted press.
- release_pulse  output  1  one-cycle pulse on an accepted release.
- click  output  1  one-cycle pulse on an accepted press or on each auto-repeat. Drives the counter's add or sub input.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - All synchroniser flops, cnt, and all outputs go to 0; state goes to IDLE.
  - Outputs are low in the cycle after the reset edge.
- Synchroniser: btn_s is btn_in delayed through SYNC_STAGES flops. The FSM uses only btn_s.
- Every output is a registered flop. Pulses are exactly one cycle wide.
- FSM states are IDLE, ARM, HELD, REPEAT and DISARM. Per state, at each clock edge:
  - IDLE (btn_level=0): if btn_s=1, go to ARM with cnt=0.
  - ARM (btn_level=0): if btn_s=0, go to IDLE. Else if cnt==DEBOUNCE_CYCLES-1, go to HELD with cnt=0, and set btn_level=1, press_pulse=1, click=1. Else cnt+1.
  - HELD (btn_level=1): if btn_s=0, go to DISARM with cnt=0. Else if repeat_en=0, hold cnt=0. Else if cnt==REPEAT_DELAY-1, go to REPEAT with cnt=0 and click=1. Else cnt+1.
  - REPEAT (btn_level=1): if btn_s=0, go to DISARM with cnt=0. Else if repeat_en=0, go to HELD with cnt=0. Else if cnt==REPEAT_PERIOD-1, set click=1 and cnt=0. Else cnt+1.
  - DISARM (btn_level=1): if btn_s=1, go to HELD with cnt=0; no pulse, and the repeat delay restarts. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE, set btn_level=0, release_pulse=1. Else cnt+1.
- Priority within a state: the btn_s test first, then repeat_en, then the cnt compare.
- Latency, numbering the first edge that samples the new btn_in level as edge 1:
  - press_pulse and click rise on edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - release_pulse rises on edge SYNC_STAGES+DEBOUNCE_CYCLES+1 after btn_in falls.
- Glitch rejection: a btn_s level run shorter than DEBOUNCE_CYCLES produces no pulse and no btn_level change.
- Auto-repeat timing: the first repeat click is REPEAT_DELAY edges after the press pulse edge. Later repeat clicks follow every REPEAT_PERIOD edges.
- press_pulse and release_pulse can never be high in the same cycle.
- cnt never wraps; every compare is exact equality.
- Reset mid-hold: if the button is still held when reset is released, a fresh press is produced after the full latency.

Test Plan:
Common parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_PERIOD=3. Edge 1 is the first edge sampling btn_in=1.
- Glitch: btn_in=1 for 3 cycles, then 0 -> press_pulse, click and btn_level stay 0 throughout.
- Clean press, repeat_en=0, btn_in=1 for 20 cycles, then 0 -> press_pulse=click=1 only after edge 7; btn_level=1 from edge 7. release_pulse fires once, 7 edges after the fall, and btn_level=0 from that point.
- Auto-repeat, repeat_en=1, btn_in held for 25 edges -> click rises on edges 7, 13, 16, 19, 22, 25. press_pulse fires only on edge 7.
- Release bounce: held in HELD, btn_in=0 for 2 cycles then 1 -> no release_pulse, btn_level stays 1. With repeat_en=1, the next click comes 6 edges after HELD is re-entered.
- Reset mid-hold: reset=1 for 1 cycle at edge 10 while the button is held -> all outputs 0 next cycle. A new press_pulse fires 7 edges after reset deasserts.
- repeat_en dropped in REPEAT -> click stops. When it is reasserted, the first click comes 6 edges later.
